// File: rtl/lane_serializer.sv
// Frame-to-beat serializer: one header beat, then NUM_LANES lane beats, in a direction set per frame.
// Optional parity output enabled by LANE_SERIALIZER_PARITY_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for a frame
// HDR   | presenting the header byte
// LANE  | presenting lane beat cnt
module lane_serializer #(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = 42
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_foo,
  input  logic [7:0]                  in_bar,
  input  logic [NUM_LANES*LANE_W-1:0] in_baz,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_W-1:0]           out_data,
  output logic                        out_hdr,
  output logic [3:0]                  out_idx,
  output logic                        out_last
`ifdef LANE_SERIALIZER_PARITY_EN
  ,
  output logic                        out_par
`endif
);

  typedef enum logic [1:0] {IDLE, HDR, LANE} state_t;

  localparam logic [3:0] LAST = 4'(NUM_LANES - 1);

  state_t                      state;
  logic [3:0]                  cnt;
  logic [3:0]                  cnt_nxt;
  logic [3:0]                  sel_nxt;
  logic                        foo_q;
  logic [NUM_LANES*LANE_W-1:0] baz_q;
  logic [LANE_W-1:0]           lane_nxt;

  // Outputs are registered, so the mux looks one beat ahead of the current counter.
  always_comb begin
    cnt_nxt  = (state == LANE) ? cnt + 4'd1 : 4'd0;
    sel_nxt  = foo_q ? (LAST - cnt_nxt) : cnt_nxt;
    lane_nxt = baz_q[sel_nxt*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      foo_q     <= 1'b0;
      baz_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hdr   <= 1'b0;
      out_idx   <= 4'd0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            foo_q     <= in_foo;
            baz_q     <= in_baz;
            state     <= HDR;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_hdr   <= 1'b1;
            out_data  <= LANE_W'(in_bar);
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        HDR, LANE: begin
          if (out_ready) begin
            if (state == LANE && cnt == LAST) begin
              state     <= IDLE;
              cnt       <= 4'd0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_hdr   <= 1'b0;
              out_idx   <= 4'd0;
              out_last  <= 1'b0;
            end else begin
              state    <= LANE;
              cnt      <= cnt_nxt;
              out_hdr  <= 1'b0;
              out_data <= lane_nxt;
              out_idx  <= sel_nxt;
              out_last <= (cnt_nxt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LANE_SERIALIZER_PARITY_EN
  // out_data is forced to zero whenever out_valid is low, so parity follows automatically.
  assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_lane_serializer.sv
// Scoreboard bench for lane_serializer: stimulus pushes expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lane_serializer;
  localparam int N = 8;
  localparam int W = 42;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_foo = 1'b0;
  logic [7:0]     in_bar = 8'h00;
  logic [N*W-1:0] in_baz = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_hdr;
  logic [3:0]     out_idx;
  logic           out_last;
`ifdef LANE_SERIALIZER_PARITY_EN
  logic           out_par;
`endif

  lane_serializer #(.NUM_LANES(N), .LANE_W(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid(in_valid), .in_ready(in_ready), .in_foo(in_foo), .in_bar(in_bar), .in_baz(in_baz),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_hdr(out_hdr),
    .out_idx(out_idx), .out_last(out_last)
`ifdef LANE_SERIALIZER_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0] data;
    logic         hdr;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  // Monitor: sampled mid-cycle, away from the rising edge.
  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge clk_i) begin : monitor
    beat_t cur;
    beat_t e;
    cur = {out_data, out_hdr, out_idx, out_last};
    if (!rst_ni) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      if (stalled) chk("stall_hold", cur, held);
`ifdef LANE_SERIALIZER_PARITY_EN
      chk("parity", out_par, ^out_data);
`endif
      if (out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat", cur);
        else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = cur;
      end
    end else begin
      if (stalled) fail_now("valid_dropped_in_stall", cur);
      stalled = 1'b0;
      chk("idle_outputs_zero", cur, 0);
`ifdef LANE_SERIALIZER_PARITY_EN
      chk("idle_par_zero", out_par, 0);
`endif
    end
  end

  task automatic push_frame(input bit foo, input logic [7:0] bar, input logic [N*W-1:0] baz,
                            input int nlanes);
    beat_t b;
    b.data = W'(bar); b.hdr = 1'b1; b.idx = 4'd0; b.last = 1'b0;
    exp_q.push_back(b);
    for (int k = 0; k < nlanes; k++) begin
      int l;
      l = foo ? (N - 1 - k) : k;
      b.data = baz[l*W +: W];
      b.hdr  = 1'b0;
      b.idx  = 4'(l);
      b.last = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // Called just after a rising edge with in_ready expected high; returns just after the accept edge.
  task automatic accept(input bit foo, input logic [7:0] bar, input logic [N*W-1:0] baz,
                        input bit hold, input int nlanes);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; in_foo = foo; in_bar = bar; in_baz = baz;
    push_frame(foo, bar, baz, nlanes);
    @(posedge clk_i); #1;
    if (!hold) in_valid = 1'b0;
    chk("in_ready_low_after_accept", in_ready, 0);
    chk("hdr_presented", {out_valid, out_hdr}, 2'b11);
  endtask

  // Counts rising edges until in_ready returns; out_ready either constant 1 or toggling from 0.
  task automatic drain(input bit toggle, input int exp_edges, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      out_ready = toggle ? n[0] : 1'b1;
      @(posedge clk_i); #1;
      n++;
    end
    out_ready = 1'b1;
    chk(name, n, exp_edges);
  endtask

  logic [N*W-1:0] baz_a, baz_b, baz_p;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int i = 0; i < N; i++) begin
      baz_a[i*W +: W] = W'(i + 1);
      baz_b[i*W +: W] = W'(32'h100 + i);
    end
    baz_p = '0;
    baz_p[0 +: W] = 42'h7;
    baz_p[W +: W] = 42'h3;

    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_data, out_hdr, out_idx, out_last}, 0);
    #20;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("in_ready_after_reset", in_ready, 1);

    out_ready = 1'b1;
    accept(1'b0, 8'hA5, baz_a, 1'b0, N);
    drain(1'b0, 9, "frame_foo0_edges");

    accept(1'b1, 8'hA5, baz_a, 1'b0, N);
    drain(1'b0, 9, "frame_foo1_edges");

    accept(1'b0, 8'hA5, baz_a, 1'b0, N);
    drain(1'b1, 18, "frame_toggle_edges");

    accept(1'b1, 8'hA5, baz_a, 1'b1, N);
    in_bar = 8'h3C; in_baz = baz_b; in_foo = 1'b0;
    drain(1'b0, 9, "frame_held_valid_edges");
    accept(1'b0, 8'h3C, baz_b, 1'b0, N);
    drain(1'b0, 9, "frame_3c_edges");

`ifdef LANE_SERIALIZER_PARITY_EN
    accept(1'b0, 8'h00, baz_p, 1'b0, N);
    @(posedge clk_i); #1;
    chk("par_lane_7", out_par, 1);
    @(posedge clk_i); #1;
    chk("par_lane_3", out_par, 0);
    drain(1'b0, 7, "frame_parity_edges");
`endif

    accept(1'b0, 8'h5A, baz_a, 1'b0, 3);
    repeat (4) @(posedge clk_i);
    #1;
    chk("pre_reset_idx", out_idx, 3);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_outputs", {out_data, out_hdr, out_idx, out_last}, 0);
    #20;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("in_ready_after_midframe_reset", in_ready, 1);
    repeat (12) @(posedge clk_i);
    #1;
    chk("no_residual_beats", out_valid, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
